// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner with frame-aligned value commit,
// hex decode, optional leading-zero blanking and per-digit decimal points.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      pend_val;
    logic [3:0]       pend_dp;
    logic             pend_flag;
    logic [15:0]      disp_val;
    logic [3:0]       disp_dp;
    logic             tick;
    logic             commit;
    logic [3:0]       nib;
    logic             blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick   = (cnt == CNT_MAX);
    assign commit = tick && (idx == 2'd3);

    // Prescaler, scan and commit: a load on the commit edge bypasses the pending register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= 2'd0;
            pend_flag   <= 1'b0;
            disp_val    <= 16'h0000;
            disp_dp     <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= tick ? '0 : cnt + CNT_W'(1);
            frame_start <= commit;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (commit) begin
                pend_flag <= 1'b0;
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_mask;
                end else if (pend_flag) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                end
            end else if (load) begin
                pend_flag <= 1'b1;
            end
        end
    end

    // Pending data is qualified by pend_flag, so it needs no reset
    always_ff @(posedge clk) begin
        if (load) begin
            pend_val <= value;
            pend_dp  <= dp_mask;
        end
    end

    always_comb begin
        nib   = 4'h0;
        blank = 1'b0;
        case (idx)
            2'd0: nib = disp_val[3:0];
            2'd1: begin
                nib   = disp_val[7:4];
                blank = (disp_val[15:4] == 12'h000);
            end
            2'd2: begin
                nib   = disp_val[11:8];
                blank = (disp_val[15:8] == 8'h00);
            end
            default: begin
                nib   = disp_val[15:12];
                blank = (disp_val[15:12] == 4'h0);
            end
        endcase
        if (!BLANK_LZ) begin
            blank = 1'b0;
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else if (blank) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << idx);
            seg <= hex7(nib);
            dp  <= ~disp_dp[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at REFRESH_DIV = 4 (16-cycle frames),
// with a second instance built without leading-zero blanking.
module tb_seven_seg_scanner;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [6:0]  seg1, seg2;
    logic        dp1, dp2;
    logic [3:0]  an1, an2;
    logic        fs1, fs2;

    int n_assert = 0;
    int n_fail   = 0;

    seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
        .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1)
    );

    seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_nolz (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_mask(dp_mask),
        .seg(seg2), .dp(dp2), .an(an2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string tag);
        int k;
        k = 0;
        cyc(1);
        while (fs1 !== 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        chk({tag, " frame_start seen"}, 16'(fs1), 16'h1);
    endtask

    // Called right after a commit edge; checks each digit slot of the following frame.
    task automatic check_frame(input bit nolz, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] lit, input logic [3:0] dpx, input string name);
        logic [6:0] es;
        logic [3:0] ea;
        chk({name, " fs entry"}, 16'(nolz ? fs2 : fs1), 16'h1);
        for (int s = 0; s < 4; s++) begin
            cyc(1);
            es = (s == 0) ? s0 : (s == 1) ? s1 : (s == 2) ? s2 : s3;
            ea = lit[s] ? ~(4'b0001 << s) : 4'b1111;
            chk($sformatf("%s d%0d an", name, s),  16'(nolz ? an2 : an1),   16'(ea));
            chk($sformatf("%s d%0d seg", name, s), 16'(nolz ? seg2 : seg1), 16'(es));
            chk($sformatf("%s d%0d dp", name, s),  16'(nolz ? dp2 : dp1),   16'(dpx[s]));
            chk($sformatf("%s d%0d fs", name, s),  16'(nolz ? fs2 : fs1),   16'h0);
            cyc(3);
        end
        chk({name, " fs exit"}, 16'(nolz ? fs2 : fs1), 16'h1);
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        value   = 16'h0000;
        dp_mask = 4'h0;

        #2;
        chk("reset an", 16'(an1), 16'hF);
        chk("reset seg", 16'(seg1), 16'h7F);
        chk("reset dp", 16'(dp1), 16'h1);
        chk("reset fs", 16'(fs1), 16'h0);
        #20;
        reset = 1'b0;
        cyc(1);
        chk("first edge an", 16'(an1), 16'hE);
        chk("first edge seg", 16'(seg1), 16'h40);

        wait_fs("boot");
        check_frame(1'b0, 7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'b0001, 4'b1111, "lz zero");
        check_frame(1'b1, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 4'b1111, 4'b1111, "nolz zero");

        // Mid-frame load must not show until the commit edge
        cyc(5);
        load = 1'b1; value = 16'h1A3F; dp_mask = 4'b0100;
        cyc(1);
        load = 1'b0;
        chk("1A3F early an", 16'(an1), 16'hF);
        chk("1A3F early seg", 16'(seg1), 16'h7F);
        wait_fs("1A3F");
        check_frame(1'b0, 7'b0001110, 7'b0110000, 7'b0001000, 7'b1111001, 4'b1111, 4'b1011, "1A3F");

        // Last load before commit wins; blanked digit3 ignores its dp bit
        load = 1'b1; value = 16'h0012; dp_mask = 4'b0001;
        cyc(1);
        load = 1'b0;
        cyc(2);
        load = 1'b1; value = 16'h0BEE; dp_mask = 4'b1000;
        cyc(1);
        load = 1'b0;
        wait_fs("0BEE");
        check_frame(1'b0, 7'b0000110, 7'b0000110, 7'b0000011, 7'h7F, 4'b0111, 4'b1111, "0BEE");

        // Load coincident with the commit edge
        cyc(15);
        load = 1'b1; value = 16'h8888; dp_mask = 4'b0000;
        cyc(1);
        load = 1'b0;
        chk("8888 commit fs", 16'(fs1), 16'h1);
        chk("8888 pend_flag", 16'(u_dut.pend_flag), 16'h0);
        check_frame(1'b0, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 4'b1111, 4'b1111, "8888");

        // Reset mid-frame discards the pending load
        cyc(5);
        load = 1'b1; value = 16'h1234; dp_mask = 4'b1111;
        cyc(1);
        load = 1'b0;
        cyc(2);
        reset = 1'b1;
        #1;
        chk("midreset an", 16'(an1), 16'hF);
        chk("midreset seg", 16'(seg1), 16'h7F);
        chk("midreset dp", 16'(dp1), 16'h1);
        chk("midreset fs", 16'(fs1), 16'h0);
        cyc(2);
        #6;
        reset = 1'b0;
        cyc(1);
        chk("post reset an", 16'(an1), 16'hE);
        chk("post reset seg", 16'(seg1), 16'h40);
        wait_fs("post reset");
        check_frame(1'b0, 7'b1000000, 7'h7F, 7'h7F, 7'h7F, 4'b0001, 4'b1111, "post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
